// File: rtl/spi_stream_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_stream_fetcher
// Description : Streams consecutive words from the SPI flash read controller
//               into a small word FIFO feeding the pixel/RLE decode pipeline.
//               Issues start/continue/stop pulses to the controller, keeps CS
//               held between words, throttles on FIFO space and supports an
//               immediate restart at a new byte address.
// Ports       : clk, rstn            - clock, async active-low reset
//               enable, restart,
//               restart_addr         - stream control
//               out_data, out_valid,
//               out_ready, fifo_level- FIFO head / handshake / occupancy
//               cur_addr             - byte address of next captured word
//               ctrl_*               - controller interface (outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_stream_fetcher #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_BITS        = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
    input  logic                            restart,
    input  logic [ADDR_BITS-1:0]            restart_addr,
    output logic [DATA_WIDTH_BYTES*8-1:0]   out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [ADDR_BITS-1:0]            cur_addr,
    output logic [ADDR_BITS-1:0]            ctrl_addr,
    output logic                            ctrl_start_read,
    output logic                            ctrl_continue_read,
    output logic                            ctrl_stop_read,
    input  logic [DATA_WIDTH_BYTES*8-1:0]   ctrl_data,
    input  logic                            ctrl_busy
);

    localparam int c_DW    = DATA_WIDTH_BYTES * 8;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;  // CS released
    localparam logic [1:0] c_ST_WAIT = 2'd1;  // one word in flight
    localparam logic [1:0] c_ST_HOLD = 2'd2;  // CS held, nothing in flight

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_first_wait;

    logic [c_DW-1:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_LVL_W-1:0]   w_level_after_pop;

    logic [ADDR_BITS-1:0] r_cur_addr;
    logic [ADDR_BITS-1:0] r_ctrl_addr;
    logic                 r_start;
    logic                 r_cont;
    logic                 r_stop;

    logic                 w_pop;
    logic                 w_capture;
    logic                 w_has_space;
    logic                 w_start;
    logic                 w_cont;
    logic                 w_stop;

    assign w_pop             = (r_level != '0) && out_ready;
    assign w_level_after_pop = r_level - c_LVL_W'(w_pop);
    assign w_has_space       = (w_level_after_pop < c_LVL_W'(FIFO_DEPTH));

    // The controller raises busy one cycle after the pulse, so busy is only
    // meaningful from the second WAIT cycle onward. A restart discards the
    // in-flight word, so it blocks the capture outright.
    assign w_capture = (r_state == c_ST_WAIT) && !r_first_wait && !ctrl_busy && !restart;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_ST_IDLE;
            r_first_wait <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // Every entry into WAIT is marked by a start or continue pulse.
            r_first_wait <= w_start || w_cont;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (restart) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Wait out a pending stop pulse before a fresh start.
                    if (enable && !r_stop) begin
                        w_next_state = c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (!r_first_wait && !ctrl_busy) begin
                        w_next_state = c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (!enable) begin
                        w_next_state = c_ST_IDLE;
                    end else if (w_has_space) begin
                        w_next_state = c_ST_WAIT;
                    end
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (pulses are registered below)
    // ------------------------------------------------------------------------
    always_comb begin
        w_start = 1'b0;
        w_cont  = 1'b0;
        w_stop  = 1'b0;
        if (restart) begin
            w_stop = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: w_start = enable && !r_stop;
                c_ST_HOLD: begin
                    if (!enable) begin
                        w_stop = 1'b1;
                    end else begin
                        w_cont = w_has_space;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start     <= 1'b0;
            r_cont      <= 1'b0;
            r_stop      <= 1'b0;
            r_ctrl_addr <= '0;
        end else begin
            r_start <= w_start;
            r_cont  <= w_cont;
            r_stop  <= w_stop;
            if (w_start) begin
                r_ctrl_addr <= r_cur_addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stream address
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur_addr <= '0;
        end else if (restart) begin
            r_cur_addr <= restart_addr;
        end else if (w_capture) begin
            r_cur_addr <= r_cur_addr + ADDR_BITS'(DATA_WIDTH_BYTES);
        end
    end

    // ------------------------------------------------------------------------
    // Word FIFO. Space is checked before each read is issued, so a capture
    // never meets a full FIFO without a simultaneous pop.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (restart) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= r_level + c_LVL_W'(w_capture) - c_LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_capture) begin
            r_mem[r_wr_ptr] <= ctrl_data;
        end
    end

    assign out_data           = r_mem[r_rd_ptr];
    assign out_valid          = (r_level != '0);
    assign fifo_level         = r_level;
    assign cur_addr           = r_cur_addr;
    assign ctrl_addr          = r_ctrl_addr;
    assign ctrl_start_read    = r_start;
    assign ctrl_continue_read = r_cont;
    assign ctrl_stop_read     = r_stop;

endmodule
`default_nettype wire

// File: tb/tb_spi_stream_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_stream_fetcher
// Description : Directed self-checking bench for spi_stream_fetcher with a
//               small behavioural model of the SPI flash read controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_stream_fetcher;

    logic        clk          = 1'b0;
    logic        rstn         = 1'b0;
    logic        enable       = 1'b0;
    logic        restart      = 1'b0;
    logic [15:0] restart_addr = '0;
    logic        out_ready    = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic [15:0] cur_addr;
    logic [15:0] ctrl_addr;
    logic        ctrl_start_read;
    logic        ctrl_continue_read;
    logic        ctrl_stop_read;
    logic [31:0] ctrl_data    = '0;
    logic        ctrl_busy    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mdl_q[$];
    int          mdl_cnt = 0;

    spi_stream_fetcher #(
        .DATA_WIDTH_BYTES (4),
        .ADDR_BITS        (16),
        .FIFO_DEPTH       (4)
    ) u_dut (
        .clk                (clk),
        .rstn               (rstn),
        .enable             (enable),
        .restart            (restart),
        .restart_addr       (restart_addr),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .fifo_level         (fifo_level),
        .cur_addr           (cur_addr),
        .ctrl_addr          (ctrl_addr),
        .ctrl_start_read    (ctrl_start_read),
        .ctrl_continue_read (ctrl_continue_read),
        .ctrl_stop_read     (ctrl_stop_read),
        .ctrl_data          (ctrl_data),
        .ctrl_busy          (ctrl_busy)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises the cycle after a start/continue pulse,
    // stays high four cycles, then drops with the next queued word on data.
    // A stop while busy aborts the word, which is consumed and never shown.
    always @(posedge clk) begin
        if (ctrl_stop_read && ctrl_busy) begin
            ctrl_busy <= 1'b0;
            if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        end else if (ctrl_start_read || ctrl_continue_read) begin
            ctrl_busy <= 1'b1;
            mdl_cnt   <= 3;
        end else if (ctrl_busy) begin
            if (mdl_cnt == 0) begin
                ctrl_busy <= 1'b0;
                ctrl_data <= (mdl_q.size() > 0) ? mdl_q.pop_front() : 32'hEEEE_EEEE;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // 0 start, 1 continue, 2 stop, 3 busy high, 4 busy low, 5 level == arg
    function automatic bit cond(input int which, input int arg);
        case (which)
            0:       return ctrl_start_read;
            1:       return ctrl_continue_read;
            2:       return ctrl_stop_read;
            3:       return ctrl_busy;
            4:       return !ctrl_busy;
            default: return (32'(fifo_level) == arg);
        endcase
    endfunction

    task automatic wait_cond(input string tag, input int which, input int arg, input int limit);
        bit found;
        found = 1'b0;
        for (int k = 0; k < limit && !found; k++) begin
            if (cond(which, arg)) found = 1'b1;
            else @(negedge clk);
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int          n_cnt;
        logic [31:0] exp_w [3];

        mdl_q.push_back(32'h1122_3344);
        mdl_q.push_back(32'h5566_7788);
        mdl_q.push_back(32'h99AA_BBCC);
        mdl_q.push_back(32'hDDEE_FF00);
        mdl_q.push_back(32'h0102_0304);
        mdl_q.push_back(32'h0506_0708);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_cur_addr", 32'(cur_addr), 32'd0);
        chk("rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
        chk("rst_pulses", 32'({ctrl_start_read, ctrl_continue_read, ctrl_stop_read}), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Restart at 0x0100 with enable high
        enable       = 1'b1;
        restart_addr = 16'h0100;
        restart      = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs1_stop", 32'(ctrl_stop_read), 32'd1);
        chk("rs1_no_start", 32'(ctrl_start_read), 32'd0);
        chk("rs1_cur_addr", 32'(cur_addr), 32'h0100);
        wait_cond("rs1_start_seen", 0, 0, 10);
        chk("rs1_ctrl_addr", 32'(ctrl_addr), 32'h0100);
        wait_cond("lvl2_seen", 5, 2, 40);
        chk("lvl2_head", out_data, 32'h1122_3344);
        chk("lvl2_cur_addr", 32'(cur_addr), 32'h0108);

        // Fill with no consumer
        wait_cond("lvl4_seen", 5, 4, 60);
        chk("lvl4_cur_addr", 32'(cur_addr), 32'h0110);
        n_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ctrl_continue_read) n_cnt++;
        end
        chk("full_no_cont", 32'(n_cnt), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_head", out_data, 32'h1122_3344);

        // One pop -> exactly one continue
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop1_cont", 32'(ctrl_continue_read), 32'd1);
        chk("pop1_level", 32'(fifo_level), 32'd3);
        chk("pop1_head", out_data, 32'h5566_7788);
        n_cnt = 1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ctrl_continue_read) n_cnt++;
        end
        chk("pop1_cont_count", 32'(n_cnt), 32'd1);
        chk("pop1_refill_level", 32'(fifo_level), 32'd4);

        // Pop coincident with capture, then stop via enable low
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_cond("pc_busy_hi", 3, 0, 10);
        wait_cond("pc_busy_lo", 4, 0, 10);
        out_ready = 1'b1;
        enable    = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pc_level", 32'(fifo_level), 32'd3);
        chk("pc_head", out_data, 32'hDDEE_FF00);
        @(negedge clk);
        chk("pc_stop", 32'(ctrl_stop_read), 32'd1);
        exp_w[0] = 32'hDDEE_FF00;
        exp_w[1] = 32'h0102_0304;
        exp_w[2] = 32'h0506_0708;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("order_%0d", i), out_data, exp_w[i]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_cur_addr", 32'(cur_addr), 32'h0118);

        // Resume, then drop enable while a word is in flight
        mdl_q.push_back(32'hCAFE_F00D);
        mdl_q.push_back(32'hBADB_AD00);
        mdl_q.push_back(32'h0BAD_F00D);
        enable = 1'b1;
        wait_cond("en_start_seen", 0, 0, 10);
        chk("en_ctrl_addr", 32'(ctrl_addr), 32'h0118);
        enable = 1'b0;
        wait_cond("en_lvl1_seen", 5, 1, 20);
        chk("en_head", out_data, 32'hCAFE_F00D);
        chk("en_cur_addr", 32'(cur_addr), 32'h011C);
        wait_cond("en_stop_seen", 2, 0, 5);
        n_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ctrl_start_read || ctrl_continue_read) n_cnt++;
        end
        chk("dis_no_read", 32'(n_cnt), 32'd0);
        enable = 1'b1;
        wait_cond("re_start_seen", 0, 0, 10);
        chk("re_ctrl_addr", 32'(ctrl_addr), 32'h011C);

        // Restart while busy
        wait_cond("rs2_busy_hi", 3, 0, 10);
        restart_addr = 16'h2000;
        restart      = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs2_stop", 32'(ctrl_stop_read), 32'd1);
        chk("rs2_level", 32'(fifo_level), 32'd0);
        chk("rs2_valid", 32'(out_valid), 32'd0);
        chk("rs2_cur_addr", 32'(cur_addr), 32'h2000);
        wait_cond("rs2_start_seen", 0, 0, 10);
        chk("rs2_ctrl_addr", 32'(ctrl_addr), 32'h2000);
        wait_cond("rs2_lvl1_seen", 5, 1, 20);
        chk("rs2_head", out_data, 32'h0BAD_F00D);

        // Address wrap
        restart_addr = 16'hFFF8;
        restart      = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("wr_cur0", 32'(cur_addr), 32'hFFF8);
        chk("wr_level0", 32'(fifo_level), 32'd0);
        wait_cond("wr_lvl1", 5, 1, 30);
        chk("wr_cur1", 32'(cur_addr), 32'hFFFC);
        wait_cond("wr_lvl2", 5, 2, 30);
        chk("wr_cur2", 32'(cur_addr), 32'h0000);
        wait_cond("wr_lvl3", 5, 3, 30);
        chk("wr_cur3", 32'(cur_addr), 32'h0004);

        // Asynchronous reset mid-WAIT
        wait_cond("ar_busy_hi", 3, 0, 10);
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_level", 32'(fifo_level), 32'd0);
        chk("ar_data", out_data, 32'd0);
        chk("ar_cur_addr", 32'(cur_addr), 32'd0);
        chk("ar_ctrl_addr", 32'(ctrl_addr), 32'd0);
        chk("ar_pulses", 32'({ctrl_start_read, ctrl_continue_read, ctrl_stop_read}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
